// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port between NUM_REQ writeback sources.
// Define WB_BYPASS_EN to forward the in-flight write to the read ports; otherwise reads pass straight through.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 16
) (
   input  logic                        r_clk,
   input  logic                        reset_n,
   input  logic                        r_clk_enable,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        write_control,
   output logic [ADDR_W-1:0]           write_reg,
   output logic [DATA_W-1:0]           write_data,
   output logic [CNT_W-1:0]            commit_cnt,
   input  logic [ADDR_W-1:0]           rd_reg1,
   input  logic [ADDR_W-1:0]           rd_reg2,
   input  logic [DATA_W-1:0]           rf_data1,
   input  logic [DATA_W-1:0]           rf_data2,
   output logic [DATA_W-1:0]           fwd_data1,
   output logic [DATA_W-1:0]           fwd_data2
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NUM_REQ_L = (PTR_W+1)'(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W:0]     cand;
   logic               found;
   logic [NUM_REQ-1:0] grant_vec;
   logic [ADDR_W-1:0]  win_reg;
   logic [DATA_W-1:0]  win_data;

   // Search starts at rr_ptr and wraps, so the most recent winner has lowest priority next.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (cand >= NUM_REQ_L)
            cand = cand - NUM_REQ_L;
         if (!found && req_valid[cand[PTR_W-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      win_reg   = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (found && win_idx == PTR_W'(i)) begin
            grant_vec[i] = 1'b1;
            win_reg      = req_reg[i*ADDR_W +: ADDR_W];
            win_data     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign next_ptr  = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
   assign req_ready = (r_clk_enable && reset_n) ? grant_vec : '0;

   always_ff @(posedge r_clk) begin
      if (!reset_n) begin
         write_control <= 1'b0;
         write_reg     <= '0;
         write_data    <= '0;
         commit_cnt    <= '0;
         rr_ptr        <= '0;
      end else if (r_clk_enable) begin
         if (found) begin
            write_reg     <= win_reg;
            write_data    <= win_data;
            write_control <= (win_reg != '0);
            rr_ptr        <= next_ptr;
            if (win_reg != '0 && commit_cnt != '1)
               commit_cnt <= commit_cnt + 1'b1;
         end else begin
            write_control <= 1'b0;
         end
      end
   end

`ifdef WB_BYPASS_EN
   assign fwd_data1 = (write_control && write_reg == rd_reg1 && rd_reg1 != '0) ? write_data : rf_data1;
   assign fwd_data2 = (write_control && write_reg == rd_reg2 && rd_reg2 != '0) ? write_data : rf_data2;
`else
   assign fwd_data1 = rf_data1;
   assign fwd_data2 = rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

   localparam int NREQ  = 3;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic                r_clk;
   logic                reset_n;
   logic                r_clk_enable;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*5-1:0]   req_reg;
   logic [NREQ*32-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                write_control;
   logic [4:0]          write_reg;
   logic [31:0]         write_data;
   logic [CNT_W-1:0]    commit_cnt;
   logic [4:0]          rd_reg1, rd_reg2;
   logic [31:0]         rf_data1, rf_data2;
   logic [31:0]         fwd_data1, fwd_data2;

   regfile_wb_arbiter #(.NUM_REQ(NREQ), .DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) dut (
      .r_clk(r_clk), .reset_n(reset_n), .r_clk_enable(r_clk_enable),
      .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
      .write_control(write_control), .write_reg(write_reg), .write_data(write_data),
      .commit_cnt(commit_cnt), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
   );

   initial begin
      r_clk = 1'b0;
      forever #5 r_clk = ~r_clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          m_ptr;
   logic        m_wc;
   logic [4:0]  m_wr;
   logic [31:0] m_wd;
   int          m_cnt;
   int          last_w;

   logic [4:0]  v_reg  [NREQ];
   logic [31:0] v_data [NREQ];

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic pack_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req_reg[i*5 +: 5]   = v_reg[i];
         req_data[i*32 +: 32] = v_data[i];
      end
   endtask

   // Inputs are already driven (negedge); checks ready/fwd before the edge, outputs after it.
   task automatic run_cycle();
      int w;
      logic [NREQ-1:0] exp_rdy;
      logic [31:0] e1, e2;
      pack_inputs();
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (m_ptr + k) % NREQ;
         if (w < 0 && req_valid[j]) w = j;
      end
      exp_rdy = (w >= 0 && r_clk_enable && reset_n) ? NREQ'(1 << w) : '0;
`ifdef WB_BYPASS_EN
      e1 = (m_wc && m_wr == rd_reg1 && rd_reg1 != 0) ? m_wd : rf_data1;
      e2 = (m_wc && m_wr == rd_reg2 && rd_reg2 != 0) ? m_wd : rf_data2;
`else
      e1 = rf_data1;
      e2 = rf_data2;
`endif
      #1;
      check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
      check_val("fwd_data1", 64'(fwd_data1), 64'(e1));
      check_val("fwd_data2", 64'(fwd_data2), 64'(e2));
      @(posedge r_clk);
      if (!reset_n) begin
         m_wc = 0; m_wr = 0; m_wd = 0; m_cnt = 0; m_ptr = 0;
      end else if (r_clk_enable) begin
         if (w >= 0) begin
            m_wr  = v_reg[w];
            m_wd  = v_data[w];
            m_wc  = (v_reg[w] != 0);
            m_ptr = (w + 1) % NREQ;
            if (m_wc && m_cnt < CMAX) m_cnt++;
         end else begin
            m_wc = 0;
         end
      end
      last_w = (exp_rdy != 0) ? w : -1;
      #1;
      check_val("write_control", 64'(write_control), 64'(m_wc));
      check_val("write_reg", 64'(write_reg), 64'(m_wr));
      check_val("write_data", 64'(write_data), 64'(m_wd));
      check_val("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
      @(negedge r_clk);
   endtask

   initial begin
      int pend [NREQ];
      m_ptr = 0; m_wc = 0; m_wr = 0; m_wd = 0; m_cnt = 0; last_w = -1;
      for (int i = 0; i < NREQ; i++) begin
         v_reg[i] = 5'(i + 1);
         v_data[i] = 32'h100 + 32'(i);
         pend[i] = 0;
      end
      rd_reg1 = 0; rd_reg2 = 0; rf_data1 = 32'h1111; rf_data2 = 32'h2222;
      reset_n = 1'b0; r_clk_enable = 1'b1; req_valid = '1;
      pack_inputs();
      @(negedge r_clk);

      // reset with all requesters valid
      run_cycle();
      run_cycle();
      check_val("rst_wc", 64'(write_control), 64'(0));
      check_val("rst_cnt", 64'(commit_cnt), 64'(0));

      // single write to r5
      reset_n = 1'b1; req_valid = 3'b001; v_reg[0] = 5'd5; v_data[0] = 32'hDEADBEEF;
      run_cycle();
      check_val("t2_grant", 64'(last_w), 64'(0));
      check_val("t2_reg", 64'(write_reg), 64'(5));
      check_val("t2_data", 64'(write_data), 64'hDEADBEEF);
      check_val("t2_cnt", 64'(commit_cnt), 64'(1));

      // all three valid: rotation 1,2,0,1,2,0
      req_valid = 3'b111;
      for (int i = 0; i < NREQ; i++) v_reg[i] = 5'(i + 1);
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < NREQ; i++) v_data[i] = 32'(c * 16 + i);
         run_cycle();
         check_val("t3_grant", 64'(last_w), 64'((c + 1) % NREQ));
         check_val("t3_wc", 64'(write_control), 64'(1));
      end

      // register-0 write is accepted but not committed
      req_valid = 3'b010; v_reg[1] = 5'd0; v_data[1] = 32'd7;
      run_cycle();
      check_val("t4_grant", 64'(last_w), 64'(1));
      check_val("t4_wc", 64'(write_control), 64'(0));

      // grant r9 from req2, stall 3 cycles, then re-enable with nothing pending
      req_valid = 3'b100; v_reg[2] = 5'd9; v_data[2] = 32'h99;
      run_cycle();
      req_valid = 3'b000; r_clk_enable = 1'b0;
      rd_reg1 = 5'd9; rd_reg2 = 5'd0; rf_data1 = 32'h0; rf_data2 = 32'h5;
      for (int c = 0; c < 3; c++) run_cycle();
      check_val("t5_hold_reg", 64'(write_reg), 64'(9));
      r_clk_enable = 1'b1;
      run_cycle();
      check_val("t5_after_wc", 64'(write_control), 64'(0));

      // randomized traffic honouring the hold-while-not-ready rule
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < 60);
               v_reg[i]  = 5'($urandom_range(0, 7));
               v_data[i] = $urandom;
            end
         end
         r_clk_enable = ($urandom_range(0, 99) < 80);
         reset_n      = ($urandom_range(0, 99) >= 2);
         rd_reg1  = 5'($urandom_range(0, 7));
         rd_reg2  = 5'($urandom_range(0, 7));
         rf_data1 = $urandom;
         rf_data2 = $urandom;
         run_cycle();
         for (int i = 0; i < NREQ; i++)
            pend[i] = (req_valid[i] && last_w != i) ? 1 : 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
